cpu_mem_tile: RTL and testbench
===============================

# cpu_mem_tile

Single-issue 16-bit processor core (`cpu_core`) fused with a private single-port data memory (`mem_mesh` in 1-core, no-IO configuration). Fetches one 32-bit instruction per cycle from an external combinational program store addressed by `progctr`, executes it in one cycle, and exposes memory traffic and a debug port. Leaf compute tile of the mesh CPU array.

## Interface
- DATA_WIDTH, 16, datapath and memory word width
- PC_WIDTH, 8, program counter width
- ADDR_WIDTH, 8, data address width
- SPREAD_WIDTH, 2, write-spread field width
- INSTR_WIDTH, 32, instruction width
- DEPTH, 16, data memory words (power of 2)

One clock; reset is synchronous and active-high.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  INSTR_WIDTH  instruction at `progctr`
- prng_in  in  DATA_WIDTH  random operand source
- debug_mode  in  2  00 run, 01 halt, 1x halt
- debug_sel  in  4  debug register select
- debug_we  in  1  debug write strobe
- debug_wdata  in  DATA_WIDTH  debug write data
- progctr  out  PC_WIDTH  current PC
- mem_we  out  1  memory write this cycle
- mem_waddr  out  ADDR_WIDTH  write address
- mem_wspread  out  SPREAD_WIDTH  extra consecutive words written
- mem_wdata  out  DATA_WIDTH  write data
- mem_raddr  out  ADDR_WIDTH  read-address register
- mem_rdata  out  DATA_WIDTH  mem[mem_raddr], combinational ("t")
- debug_stopped  out  1  core halted
- debug_rdata  out  DATA_WIDTH  selected debug register

## Operation
- Fields: [31:29] srcA, [28:26] srcB, [25] enable, [24:23] cond, [22:19] alu, [18:16] dest, [15:0] imm.
- Sources: 000 reg1, 001 reg2, 010 pc, 011 t, 100 imm, 101 prng_in, 110 timer, 111 constant 1.
- ALU (modulo 2^DATA_WIDTH): 0000 B, 0001 A&B, 0010 A|B, 0011 A, 0100 A^B, 0101 ~A, 0110 A<<1, 0111 A>>1 logical, 1000 A>>>1 arithmetic, 1001 (A<B signed)?1:0, 1010 A+B, 1011 A−B, 1100 (A==B)?1:0, others 0.
- Cond: 00 always, 01 iff reg1 negative (MSB=1), 10 iff reg1==0, 11 always.
- Executes iff enable=1, cond true, not halted. All-zero opcode = noop.
- Dest: 000 none, 001 reg1, 010 reg2, 011 pc, 100 mem_raddr, 101 reg1 and reg2, 110 none, 111 memory write.
- Memory write: mem_we=1, mem_waddr=imm[ADDR_WIDTH+3:4], mem_wspread=imm[1:0], mem_wdata=result. Words waddr..waddr+wspread written (index mod DEPTH, wrap).
- Reads: mem_rdata = mem[mem_raddr mod DEPTH], combinational; a write to that word is visible next cycle.
- PC: result truncated to PC_WIDTH if dest=pc, else pc+1 (wraps). Halted: held.
- Timer: free-running DATA_WIDTH counter, +1 per cycle incl. halt, wraps.
- Debug: debug_stopped = (debug_mode!=00). debug_rdata by debug_sel: 0 pc, 1 reg1, 2 reg2, 3 mem_raddr, 4 timer, 5 mem_rdata, 6 opcode[15:0], else 0. Halted and debug_we: write debug_wdata to selects 0–4; others ignored.

## Timing
- Single cycle: opcode combinational from progctr; results committed at next rising edge.
- mem_we/waddr/wspread/wdata combinational from opcode and state; 0 when not executing.
- Reset: pc, reg1, reg2, mem_raddr, timer, all memory words = 0; mem_we=0; debug_stopped follows debug_mode. Mid-run reset aborts the current instruction, no write.
- dest=pc with result==pc: stays (spin).
- Halt entered/left on any cycle; instruction at progctr executes on the first run cycle.

## Configuration
- CPU_DEBUG_EN defined: debug port as above.
- Undefined: debug inputs ignored, core always runs, debug_stopped=0, debug_rdata=0.

## Test plan
- reg1=73 (A=imm,alu=A,dest=reg1), reg2=74, jump reg1+reg2 -> progctr=147 (0x93) next cycle.
- reg1=243; mem[1]=reg1; raddr=0; mem[0]=t+1; raddr=0; raddr=t; jump t -> mem_rdata 0,1,243 in turn; progctr=243.
- Loop reg1=timer−23; if reg1<0 jump 0; else jump 44 -> loops until sampled timer≥23, then progctr=44.
- Write 0x88 to mem[2] spread 1 -> mem[2]=mem[3]=0x88; raddr=3 reads 0x88; write at addr 15 spread 2 wraps to 0,1.
- debug_mode=01 -> pc and reg frozen, timer runs; sel 1 write 0x1234 -> reg1=0x1234; sel 6 returns opcode[15:0].
- rst asserted mid-program -> next edge pc=0, regs/memory 0, mem_we=0.

Source files
------------

// File: rtl/cpu_mem_tile.sv
// cpu_mem_tile: single-issue 16-bit core fused with a private single-port data
// memory. One 32-bit instruction is fetched per cycle from an external
// combinational program store addressed by progctr and retired on the next
// rising edge.
//
// Optional feature macro: CPU_DEBUG_EN. When it is defined, the debug port
// halts the core and gives register read/write access. When it is undefined,
// the debug inputs are ignored, the core always runs, and debug_stopped and
// debug_rdata are 0.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset
//   opcode         instruction word at progctr
//   prng_in        random operand source
//   debug_mode     00 run, anything else halt
//   debug_sel      debug register select (0 pc, 1 reg1, 2 reg2, 3 mem_raddr,
//                  4 timer, 5 mem_rdata, 6 opcode[15:0])
//   debug_we       debug write strobe (selects 0-4, only while halted)
//   debug_wdata    debug write data
//   progctr        current program counter
//   mem_we         memory write this cycle
//   mem_waddr      memory write address
//   mem_wspread    number of extra consecutive words written
//   mem_wdata      memory write data
//   mem_raddr      memory read-address register
//   mem_rdata      mem[mem_raddr], combinational (source "t")
//   debug_stopped  core is halted
//   debug_rdata    selected debug register
module cpu_mem_tile #(
   parameter int unsigned DATA_WIDTH   = 16,
   parameter int unsigned PC_WIDTH     = 8,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned SPREAD_WIDTH = 2,
   parameter int unsigned INSTR_WIDTH  = 32,
   parameter int unsigned DEPTH        = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [INSTR_WIDTH-1:0]  opcode,
   input  logic [DATA_WIDTH-1:0]   prng_in,
   input  logic [1:0]              debug_mode,
   input  logic [3:0]              debug_sel,
   input  logic                    debug_we,
   input  logic [DATA_WIDTH-1:0]   debug_wdata,
   output logic [PC_WIDTH-1:0]     progctr,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_waddr,
   output logic [SPREAD_WIDTH-1:0] mem_wspread,
   output logic [DATA_WIDTH-1:0]   mem_wdata,
   output logic [ADDR_WIDTH-1:0]   mem_raddr,
   output logic [DATA_WIDTH-1:0]   mem_rdata,
   output logic                    debug_stopped,
   output logic [DATA_WIDTH-1:0]   debug_rdata
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      SRC_REG1  = 3'b000,
      SRC_REG2  = 3'b001,
      SRC_PC    = 3'b010,
      SRC_T     = 3'b011,
      SRC_IMM   = 3'b100,
      SRC_PRNG  = 3'b101,
      SRC_TIMER = 3'b110,
      SRC_ONE   = 3'b111
   } src_e;

   typedef enum logic [3:0] {
      ALU_B   = 4'b0000,
      ALU_AND = 4'b0001,
      ALU_OR  = 4'b0010,
      ALU_A   = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_NOT = 4'b0101,
      ALU_SHL = 4'b0110,
      ALU_SHR = 4'b0111,
      ALU_SAR = 4'b1000,
      ALU_SLT = 4'b1001,
      ALU_ADD = 4'b1010,
      ALU_SUB = 4'b1011,
      ALU_EQ  = 4'b1100
   } alu_e;

   typedef enum logic [1:0] {
      COND_ALWAYS     = 2'b00,
      COND_NEG        = 2'b01,
      COND_ZERO       = 2'b10,
      COND_ALWAYS_ALT = 2'b11
   } cond_e;

   typedef enum logic [2:0] {
      DST_NONE     = 3'b000,
      DST_REG1     = 3'b001,
      DST_REG2     = 3'b010,
      DST_PC       = 3'b011,
      DST_RADDR    = 3'b100,
      DST_BOTH     = 3'b101,
      DST_NONE_ALT = 3'b110,
      DST_MEM      = 3'b111
   } dst_e;

   // Architectural state
   logic [DATA_WIDTH-1:0] reg1;
   logic [DATA_WIDTH-1:0] reg2;
   logic [DATA_WIDTH-1:0] timer;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Instruction fields
   src_e                  src_a;
   src_e                  src_b;
   logic                  enable;
   cond_e                 cond;
   alu_e                  alu_op;
   dst_e                  dest;
   logic [DATA_WIDTH-1:0] imm;

   logic [DATA_WIDTH-1:0] opa;
   logic [DATA_WIDTH-1:0] opb;
   logic [DATA_WIDTH-1:0] result;
   logic                  cond_ok;
   logic                  exec;
   logic                  halted;
   logic                  dbg_wr;
   logic [IDX_W-1:0]      waddr_idx;
   logic [DEPTH-1:0]      word_we;

   assign src_a  = src_e'(opcode[31:29]);
   assign src_b  = src_e'(opcode[28:26]);
   assign enable = opcode[25];
   assign cond   = cond_e'(opcode[24:23]);
   assign alu_op = alu_e'(opcode[22:19]);
   assign dest   = dst_e'(opcode[18:16]);
   assign imm    = DATA_WIDTH'(opcode[15:0]);

   assign mem_rdata = mem[mem_raddr[IDX_W-1:0]];

   function automatic logic [DATA_WIDTH-1:0] operand(input src_e sel);
      logic [DATA_WIDTH-1:0] val;
      val = '0;
      case (sel)
         SRC_REG1:  val = reg1;
         SRC_REG2:  val = reg2;
         SRC_PC:    val = DATA_WIDTH'(progctr);
         SRC_T:     val = mem_rdata;
         SRC_IMM:   val = imm;
         SRC_PRNG:  val = prng_in;
         SRC_TIMER: val = timer;
         default:   val = DATA_WIDTH'(1);
      endcase
      return val;
   endfunction

   always_comb begin
      opa = operand(src_a);
      opb = operand(src_b);
   end

   always_comb begin
      result = '0;
      case (alu_op)
         ALU_B:   result = opb;
         ALU_AND: result = opa & opb;
         ALU_OR:  result = opa | opb;
         ALU_A:   result = opa;
         ALU_XOR: result = opa ^ opb;
         ALU_NOT: result = ~opa;
         ALU_SHL: result = {opa[DATA_WIDTH-2:0], 1'b0};
         ALU_SHR: result = {1'b0, opa[DATA_WIDTH-1:1]};
         ALU_SAR: result = {opa[DATA_WIDTH-1], opa[DATA_WIDTH-1:1]};
         ALU_SLT: result = DATA_WIDTH'($signed(opa) < $signed(opb));
         ALU_ADD: result = opa + opb;
         ALU_SUB: result = opa - opb;
         ALU_EQ:  result = DATA_WIDTH'(opa == opb);
         default: result = '0;
      endcase
   end

   always_comb begin
      cond_ok = 1'b1;
      case (cond)
         COND_NEG:  cond_ok = reg1[DATA_WIDTH-1];
         COND_ZERO: cond_ok = (reg1 == '0);
         default:   cond_ok = 1'b1;
      endcase
   end

   // Reset is folded in so an instruction in flight during reset never writes.
   assign exec = enable & cond_ok & ~halted & ~rst;

   assign mem_we      = exec && (dest == DST_MEM);
   assign mem_waddr   = mem_we ? opcode[ADDR_WIDTH+3:4] : '0;
   assign mem_wspread = mem_we ? opcode[SPREAD_WIDTH-1:0] : '0;
   assign mem_wdata   = mem_we ? result : '0;
   assign waddr_idx   = mem_waddr[IDX_W-1:0];

   // A word is hit when its distance above the start address (mod DEPTH)
   // lies within the spread, which gives wrap-around for free.
   always_comb begin
      word_we = '0;
      for (int unsigned w = 0; w < DEPTH; w++) begin
         word_we[w] = mem_we &&
                      (IDX_W'(IDX_W'(w) - waddr_idx) <= IDX_W'(mem_wspread));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (word_we[i]) begin
               mem[i] <= mem_wdata;
            end
         end
      end
   end

`ifdef CPU_DEBUG_EN
   assign halted = (debug_mode != 2'b00);
   assign dbg_wr = halted & debug_we;

   always_comb begin
      debug_rdata = '0;
      case (debug_sel)
         4'd0:    debug_rdata = DATA_WIDTH'(progctr);
         4'd1:    debug_rdata = reg1;
         4'd2:    debug_rdata = reg2;
         4'd3:    debug_rdata = DATA_WIDTH'(mem_raddr);
         4'd4:    debug_rdata = timer;
         4'd5:    debug_rdata = mem_rdata;
         4'd6:    debug_rdata = DATA_WIDTH'(opcode[15:0]);
         default: debug_rdata = '0;
      endcase
   end
`else
   logic unused_dbg;

   assign halted      = 1'b0;
   assign dbg_wr      = 1'b0;
   assign debug_rdata = '0;
   assign unused_dbg  = ^{debug_mode, debug_we};
`endif

   assign debug_stopped = halted;

   // Later assignments win: an executed dest=pc overrides the increment, and a
   // debug write (only possible while halted, so never alongside exec)
   // overrides both the hold and the free-running timer increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         progctr   <= '0;
         reg1      <= '0;
         reg2      <= '0;
         mem_raddr <= '0;
         timer     <= '0;
      end else begin
         timer <= timer + DATA_WIDTH'(1);
         if (!halted) begin
            progctr <= progctr + PC_WIDTH'(1);
         end
         if (exec) begin
            case (dest)
               DST_REG1:  reg1 <= result;
               DST_REG2:  reg2 <= result;
               DST_PC:    progctr <= result[PC_WIDTH-1:0];
               DST_RADDR: mem_raddr <= result[ADDR_WIDTH-1:0];
               DST_BOTH: begin
                  reg1 <= result;
                  reg2 <= result;
               end
               default: ;
            endcase
         end
         if (dbg_wr) begin
            case (debug_sel)
               4'd0:    progctr <= debug_wdata[PC_WIDTH-1:0];
               4'd1:    reg1 <= debug_wdata;
               4'd2:    reg2 <= debug_wdata;
               4'd3:    mem_raddr <= debug_wdata[ADDR_WIDTH-1:0];
               4'd4:    timer <= debug_wdata;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_mem_tile.sv
// Bench for cpu_mem_tile: directed programs followed by a random program and
// random side inputs. An arithmetic reference model of the tile is compared
// against every DUT output on every cycle.
module tb_cpu_mem_tile;

`ifdef CPU_DEBUG_EN
   localparam bit DBG = 1'b1;
`else
   localparam bit DBG = 1'b0;
`endif

   // Source, ALU and destination codes used to assemble programs
   localparam int unsigned S_R1 = 0, S_R2 = 1, S_T = 3, S_IMM = 4, S_TMR = 6, S_ONE = 7;
   localparam int unsigned A_PASS = 3, A_ADD = 10, A_SUB = 11;
   localparam int unsigned D_R1 = 1, D_R2 = 2, D_PC = 3, D_RA = 4, D_MEM = 7;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] opcode;
   logic [15:0] prng_in;
   logic [1:0]  debug_mode;
   logic [3:0]  debug_sel;
   logic        debug_we;
   logic [15:0] debug_wdata;
   logic [7:0]  progctr;
   logic        mem_we;
   logic [7:0]  mem_waddr;
   logic [1:0]  mem_wspread;
   logic [15:0] mem_wdata;
   logic [7:0]  mem_raddr;
   logic [15:0] mem_rdata;
   logic        debug_stopped;
   logic [15:0] debug_rdata;

   logic [31:0] prog [256];

   int checks = 0;
   int errors = 0;

   // Reference model state
   int unsigned m_pc, m_r1, m_r2, m_ra, m_tmr;
   int unsigned m_mem [16];

   always #5 clk = ~clk;

   assign opcode = prog[progctr];

   cpu_mem_tile #(
      .DATA_WIDTH  (16),
      .PC_WIDTH    (8),
      .ADDR_WIDTH  (8),
      .SPREAD_WIDTH(2),
      .INSTR_WIDTH (32),
      .DEPTH       (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .opcode       (opcode),
      .prng_in      (prng_in),
      .debug_mode   (debug_mode),
      .debug_sel    (debug_sel),
      .debug_we     (debug_we),
      .debug_wdata  (debug_wdata),
      .progctr      (progctr),
      .mem_we       (mem_we),
      .mem_waddr    (mem_waddr),
      .mem_wspread  (mem_wspread),
      .mem_wdata    (mem_wdata),
      .mem_raddr    (mem_raddr),
      .mem_rdata    (mem_rdata),
      .debug_stopped(debug_stopped),
      .debug_rdata  (debug_rdata)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int unsigned a, input int unsigned b,
                                       input int unsigned en, input int unsigned cnd,
                                       input int unsigned alu, input int unsigned dst,
                                       input int unsigned imm);
      return 32'((a << 29) | (b << 26) | (en << 25) | (cnd << 23) |
                 (alu << 19) | (dst << 16) | (imm & 32'hFFFF));
   endfunction

   function automatic int unsigned src_ref(input int unsigned s, input int unsigned imm);
      case (s)
         0: return m_r1;
         1: return m_r2;
         2: return m_pc;
         3: return m_mem[m_ra % 16];
         4: return imm;
         5: return int'(prng_in);
         6: return m_tmr;
         default: return 1;
      endcase
   endfunction

   function automatic int unsigned alu_ref(input int unsigned op, input int unsigned a,
                                           input int unsigned b);
      int sa, sb;
      sa = (a >= 32768) ? int'(a) - 65536 : int'(a);
      sb = (b >= 32768) ? int'(b) - 65536 : int'(b);
      case (op)
         0:  return b;
         1:  return a & b;
         2:  return a | b;
         3:  return a;
         4:  return a ^ b;
         5:  return 65535 - a;
         6:  return (a * 2) % 65536;
         7:  return a / 2;
         8:  return a / 2 + (a & 32768);
         9:  return (sa < sb) ? 1 : 0;
         10: return (a + b) % 65536;
         11: return (a + 65536 - b) % 65536;
         12: return (a == b) ? 1 : 0;
         default: return 0;
      endcase
   endfunction

   function automatic int unsigned dbg_ref(input int unsigned op);
      if (!DBG) return 0;
      case (debug_sel)
         4'd0: return m_pc;
         4'd1: return m_r1;
         4'd2: return m_r2;
         4'd3: return m_ra;
         4'd4: return m_tmr;
         4'd5: return m_mem[m_ra % 16];
         4'd6: return op & 16'hFFFF;
         default: return 0;
      endcase
   endfunction

   // Compare all outputs for the current cycle, advance the model across the
   // coming rising edge, and return at the following falling edge.
   task automatic step();
      int unsigned op, sa, sb, en, cnd, alu, dst, imm, res, waddr, spread;
      int unsigned npc, nr1, nr2, nra, ntmr;
      bit halted, cond_ok, exec, we;
      #1;
      op  = prog[m_pc];
      sa  = op >> 29;
      sb  = (op >> 26) & 7;
      en  = (op >> 25) & 1;
      cnd = (op >> 23) & 3;
      alu = (op >> 19) & 15;
      dst = (op >> 16) & 7;
      imm = op & 16'hFFFF;
      halted  = DBG && (debug_mode != 2'b00);
      cond_ok = (cnd == 1) ? (m_r1 >= 32768) : (cnd == 2) ? (m_r1 == 0) : 1'b1;
      exec    = (en == 1) && cond_ok && !halted && !rst;
      res     = alu_ref(alu, src_ref(sa, imm), src_ref(sb, imm));
      we      = exec && (dst == 7);
      waddr   = we ? (imm >> 4) & 255 : 0;
      spread  = we ? imm & 3 : 0;

      check("progctr", progctr, m_pc);
      check("mem_we", mem_we, we);
      check("mem_waddr", mem_waddr, waddr);
      check("mem_wspread", mem_wspread, spread);
      check("mem_wdata", mem_wdata, we ? res : 0);
      check("mem_raddr", mem_raddr, m_ra);
      check("mem_rdata", mem_rdata, m_mem[m_ra % 16]);
      check("debug_stopped", debug_stopped, halted);
      check("debug_rdata", debug_rdata, dbg_ref(op));

      if (rst) begin
         m_pc = 0; m_r1 = 0; m_r2 = 0; m_ra = 0; m_tmr = 0;
         foreach (m_mem[i]) m_mem[i] = 0;
      end else begin
         npc  = halted ? m_pc : (m_pc + 1) % 256;
         nr1  = m_r1;
         nr2  = m_r2;
         nra  = m_ra;
         ntmr = (m_tmr + 1) % 65536;
         if (exec) begin
            case (dst)
               1: nr1 = res;
               2: nr2 = res;
               3: npc = res % 256;
               4: nra = res % 256;
               5: begin nr1 = res; nr2 = res; end
               7: for (int unsigned k = 0; k <= spread; k++) m_mem[(waddr + k) % 16] = res;
               default: ;
            endcase
         end
         if (halted && debug_we) begin
            case (debug_sel)
               4'd0: npc  = int'(debug_wdata) % 256;
               4'd1: nr1  = int'(debug_wdata);
               4'd2: nr2  = int'(debug_wdata);
               4'd3: nra  = int'(debug_wdata) % 256;
               4'd4: ntmr = int'(debug_wdata);
               default: ;
            endcase
         end
         m_pc = npc; m_r1 = nr1; m_r2 = nr2; m_ra = nra; m_tmr = ntmr;
      end
      @(negedge clk);
   endtask

   task automatic clear_prog();
      foreach (prog[i]) prog[i] = 32'h0;
   endtask

   task automatic reset_run();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      bit hit;
      rst = 1'b1; prng_in = '0; debug_mode = 2'b00; debug_sel = '0;
      debug_we = 1'b0; debug_wdata = '0;
      clear_prog();
      @(posedge clk);
      @(negedge clk);
      m_pc = 0; m_r1 = 0; m_r2 = 0; m_ra = 0; m_tmr = 0;
      foreach (m_mem[i]) m_mem[i] = 0;

      // Two loads then a jump to their sum
      reset_run();
      prog[0] = enc(S_IMM, 0, 1, 0, A_PASS, D_R1, 73);
      prog[1] = enc(S_IMM, 0, 1, 0, A_PASS, D_R2, 74);
      prog[2] = enc(S_R1, S_R2, 1, 0, A_ADD, D_PC, 0);
      repeat (3) step();
      check("jump_sum_pc", progctr, 8'h93);

      // Memory store, read-back through t, jump through t
      clear_prog();
      reset_run();
      prog[0] = enc(S_IMM, 0, 1, 0, A_PASS, D_R1, 243);
      prog[1] = enc(S_R1, 0, 1, 0, A_PASS, D_MEM, 16'h0010);
      prog[2] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 0);
      prog[3] = enc(S_T, S_ONE, 1, 0, A_ADD, D_MEM, 16'h0000);
      prog[4] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 0);
      prog[5] = enc(S_T, 0, 1, 0, A_PASS, D_RA, 0);
      prog[6] = enc(S_T, 0, 1, 0, A_PASS, D_PC, 0);
      repeat (3) step();
      check("t_read_0", mem_rdata, 16'd0);
      step();
      check("t_read_1_after_write", mem_rdata, 16'd1);
      repeat (2) step();
      check("t_read_243", mem_rdata, 16'd243);
      step();
      check("jump_t_pc", progctr, 8'd243);

      // Timer-driven loop with a conditional branch on reg1 sign
      clear_prog();
      reset_run();
      prog[0] = enc(S_TMR, S_IMM, 1, 0, A_SUB, D_R1, 23);
      prog[1] = enc(S_IMM, 0, 1, 1, A_PASS, D_PC, 0);
      prog[2] = enc(S_IMM, 0, 1, 0, A_PASS, D_PC, 44);
      hit = 1'b0;
      for (int i = 0; i < 300 && !hit; i++) begin
         step();
         if (progctr == 8'd44) hit = 1'b1;
      end
      check("loop_exit_pc", progctr, 8'd44);

      // Spread writes, including wrap past the last word
      clear_prog();
      reset_run();
      prog[0] = enc(S_IMM, 0, 1, 0, A_PASS, D_R1, 16'h0088);
      prog[1] = enc(S_R1, 0, 1, 0, A_PASS, D_MEM, 16'h0021);
      prog[2] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 3);
      prog[3] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 2);
      prog[4] = enc(S_R1, 0, 1, 0, A_PASS, D_MEM, 16'h00F2);
      prog[5] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 0);
      prog[6] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 1);
      prog[7] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 15);
      prog[8] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 4);
      step();
      check("spread_waddr", mem_waddr, 8'd2);
      check("spread_wspread", mem_wspread, 2'd1);
      check("spread_wdata", mem_wdata, 16'h0088);
      repeat (2) step();
      check("spread_mem3", mem_rdata, 16'h0088);
      step();
      check("spread_mem2", mem_rdata, 16'h0088);
      check("wrap_waddr", mem_waddr, 8'd15);
      check("wrap_wspread", mem_wspread, 2'd2);
      repeat (2) step();
      check("wrap_mem0", mem_rdata, 16'h0088);
      step();
      check("wrap_mem1", mem_rdata, 16'h0088);
      step();
      check("wrap_mem15", mem_rdata, 16'h0088);
      step();
      check("untouched_mem4", mem_rdata, 16'h0000);

      // Debug halt, register write and opcode readback
      clear_prog();
      reset_run();
      prog[0] = enc(S_IMM, 0, 1, 0, A_PASS, D_R1, 73);
      prog[1] = enc(S_IMM, 0, 1, 0, A_PASS, D_R2, 74);
      prog[2] = enc(S_R1, S_R2, 1, 0, A_ADD, D_PC, 0);
`ifdef CPU_DEBUG_EN
      step();
      debug_mode = 2'b01;
      debug_sel  = 4'd4;
      repeat (4) step();
      check("halt_pc_frozen", progctr, 8'd1);
      check("halt_timer_runs", debug_rdata, 16'd5);
      debug_sel = 4'd1;
      #1;
      check("halt_reg1_kept", debug_rdata, 16'd73);
      debug_we = 1'b1; debug_wdata = 16'h1234;
      step();
      debug_we = 1'b0;
      #1;
      check("dbg_write_reg1", debug_rdata, 16'h1234);
      debug_sel = 4'd6;
      #1;
      check("dbg_opcode_low", debug_rdata, 16'h004A);
      debug_mode = 2'b00;
      repeat (2) step();
      check("resume_jump_pc", progctr, 8'h7E);
`else
      debug_mode = 2'b01; debug_we = 1'b1; debug_sel = 4'd1; debug_wdata = 16'h1234;
      repeat (3) step();
      check("nodbg_runs_pc", progctr, 8'h93);
      check("nodbg_stopped", debug_stopped, 1'b0);
      check("nodbg_rdata", debug_rdata, 16'h0000);
`endif
      debug_mode = 2'b00; debug_we = 1'b0; debug_sel = '0; debug_wdata = '0;

      // Reset in the middle of a program aborts a pending write
      clear_prog();
      reset_run();
      prog[0] = enc(S_IMM, 0, 1, 0, A_PASS, D_R1, 16'h0055);
      prog[1] = enc(S_R1, 0, 1, 0, A_PASS, D_MEM, 16'h0053);
      prog[2] = enc(S_IMM, 0, 1, 0, A_PASS, D_R2, 7);
      prog[3] = enc(S_R1, 0, 1, 0, A_PASS, D_MEM, 16'h0000);
      prog[4] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 6);
      prog[5] = enc(S_R1, 0, 1, 0, A_PASS, D_MEM, 16'h0090);
      repeat (5) step();
      check("pre_reset_mem6", mem_rdata, 16'h0055);
      rst = 1'b1;
      #1;
      check("reset_blocks_we", mem_we, 1'b0);
      step();
      rst = 1'b0;
      check("reset_pc", progctr, 8'd0);
      check("reset_raddr", mem_raddr, 8'd0);
      clear_prog();
      prog[0] = enc(S_R1, 0, 1, 0, A_PASS, D_RA, 0);
      prog[1] = enc(S_R2, 0, 1, 0, A_PASS, D_RA, 0);
      prog[2] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 5);
      prog[3] = enc(S_IMM, 0, 1, 0, A_PASS, D_RA, 9);
      step();
      check("reset_reg1", mem_raddr, 8'd0);
      check("reset_mem0", mem_rdata, 16'h0000);
      step();
      check("reset_reg2", mem_raddr, 8'd0);
      step();
      check("reset_mem5", mem_rdata, 16'h0000);
      step();
      check("aborted_mem9", mem_rdata, 16'h0000);

      // Random program with random side inputs, checked by the model
      reset_run();
      foreach (prog[i]) prog[i] = $urandom;
      for (int c = 0; c < 2000; c++) begin
         prng_in = 16'($urandom);
         if ($urandom_range(0, 19) == 0) debug_mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) debug_mode = 2'b00;
         debug_sel   = 4'($urandom);
         debug_we    = ($urandom_range(0, 3) == 0);
         debug_wdata = 16'($urandom);
         rst         = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
